// File: rtl/tl_c_sink.sv
// TileLink C-channel sink: buffers arbitrated C beats toward the memory write port and returns ReleaseAck on D.
// Optional 0-cycle path from c to oup when the beat FIFO is empty: define TL_C_SINK_BYPASS_EN.
package tl_c_sink_pkg;
    typedef struct packed {
        logic [2:0]  opcode;
        logic [2:0]  param;
        logic [9:0]  size;
        logic [3:0]  source;
        logic [31:0] address;
        logic [31:0] data;
    } tl_c_beat_t;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [2:0]  param;
        logic [9:0]  size;
        logic [3:0]  source;
        logic [1:0]  sink;
        logic        denied;
        logic [31:0] data;
    } tl_d_beat_t;
endpackage

module tl_c_sink #(
    parameter type         C_T       = tl_c_sink_pkg::tl_c_beat_t,
    parameter type         D_T       = tl_c_sink_pkg::tl_d_beat_t,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned ACK_DEPTH = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  C_T   c_bits_i,
    input  logic c_valid_i,
    output logic c_ready_o,
    output C_T   oup_bits_o,
    output logic oup_valid_o,
    input  logic oup_ready_i,
    output D_T   d_bits_o,
    output logic d_valid_o,
    input  logic d_ready_i,
    output logic busy_o,
    output logic err_o
);
    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned KW     = $clog2(ACK_DEPTH);
    localparam int unsigned SIZE_W = 10;
    localparam int unsigned SRC_W  = 4;
    localparam logic [AW:0] PTR_ONE  = 1;
    localparam logic [KW:0] KPTR_ONE = 1;
    localparam logic [SIZE_W-1:0] CNT_ONE = 1;
    localparam logic [2:0] OP_RELEASE_ACK = 3'd6;

    typedef enum logic {OUT_IDLE, OUT_BURST} out_state_e;

    C_T          beat_mem [DEPTH];
    logic [AW:0] wr_q, rd_q;
    D_T          ack_mem [ACK_DEPTH];
    logic [KW:0] ack_wr_q, ack_rd_q;

    out_state_e        state_q;
    logic [SIZE_W-1:0] cnt_q;
    logic [SIZE_W-1:0] size_q;
    logic [SRC_W-1:0]  src_q;
    logic              rel_q;
    logic              err_q;

    logic beat_empty, beat_full, ack_empty, ack_full;
    logic use_bypass, head_valid, head_first, head_legal, head_rel, head_last;
    logic ack_stall, oup_fire, c_fire, beat_push, beat_pop, ack_push, ack_pop;
    C_T   head;
    D_T   ack_entry;

    assign beat_empty = (wr_q == rd_q);
    assign beat_full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign ack_empty  = (ack_wr_q == ack_rd_q);
    assign ack_full   = (ack_wr_q[KW] != ack_rd_q[KW]) && (ack_wr_q[KW-1:0] == ack_rd_q[KW-1:0]);

`ifdef TL_C_SINK_BYPASS_EN
    assign use_bypass = beat_empty;
    assign head       = beat_empty ? c_bits_i : beat_mem[rd_q[AW-1:0]];
    assign head_valid = !beat_empty || c_valid_i;
    assign c_ready_o  = !beat_full || (beat_empty && oup_ready_i);
`else
    assign use_bypass = 1'b0;
    assign head       = beat_mem[rd_q[AW-1:0]];
    assign head_valid = !beat_empty;
    assign c_ready_o  = !beat_full;
`endif

    // Opcodes 4..7 are legal on C; 6/7 (Release/ReleaseData) require an ack.
    assign head_first = (state_q == OUT_IDLE);
    assign head_legal = head.opcode[2];
    assign head_rel   = head_first ? (head.opcode[2:1] == 2'b11) : rel_q;
    assign head_last  = head_first ? !(head_legal && (head.size != '0)) : (cnt_q == CNT_ONE);
    assign ack_stall  = head_last && head_rel && ack_full;

    assign oup_valid_o = head_valid && !ack_stall;
    assign oup_bits_o  = head;
    assign oup_fire    = oup_valid_o && oup_ready_i;
    assign c_fire      = c_valid_i && c_ready_o;
    assign beat_push   = c_fire && !(use_bypass && oup_fire);
    assign beat_pop    = oup_fire && !beat_empty;
    assign ack_push    = oup_fire && head_last && head_rel;
    assign ack_pop     = d_valid_o && d_ready_i;

    always_comb begin
        ack_entry        = '0;
        ack_entry.opcode = OP_RELEASE_ACK;
        ack_entry.param  = '0;
        ack_entry.size   = head_first ? head.size : size_q;
        ack_entry.source = head_first ? head.source : src_q;
    end

    assign d_valid_o = !ack_empty;
    assign d_bits_o  = ack_mem[ack_rd_q[KW-1:0]];
    assign busy_o    = !beat_empty || (state_q == OUT_BURST) || !ack_empty;
    assign err_o     = err_q;

    always_ff @(posedge clk_i) begin
        if (beat_push) begin
            beat_mem[wr_q[AW-1:0]] <= c_bits_i;
        end
        if (ack_push) begin
            ack_mem[ack_wr_q[KW-1:0]] <= ack_entry;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_q     <= '0;
            rd_q     <= '0;
            ack_wr_q <= '0;
            ack_rd_q <= '0;
        end else begin
            if (beat_push) wr_q <= wr_q + PTR_ONE;
            if (beat_pop)  rd_q <= rd_q + PTR_ONE;
            if (ack_push)  ack_wr_q <= ack_wr_q + KPTR_ONE;
            if (ack_pop)   ack_rd_q <= ack_rd_q + KPTR_ONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= OUT_IDLE;
            cnt_q   <= '0;
            size_q  <= '0;
            src_q   <= '0;
            rel_q   <= 1'b0;
            err_q   <= 1'b0;
        end else if (oup_fire) begin
            case (state_q)
                OUT_IDLE: begin
                    if (!head_legal) begin
                        err_q <= 1'b1;
                    end else if (head.size != '0) begin
                        cnt_q   <= head.size;
                        size_q  <= head.size;
                        src_q   <= head.source;
                        rel_q   <= (head.opcode[2:1] == 2'b11);
                        state_q <= OUT_BURST;
                    end
                end
                OUT_BURST: begin
                    cnt_q <= cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) state_q <= OUT_IDLE;
                end
                default: state_q <= OUT_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tl_c_sink.sv
// Self-checking bench for tl_c_sink: queue-based reference model plus directed and random C traffic.
module tb_tl_c_sink;
    import tl_c_sink_pkg::*;

    localparam int DEPTH     = 4;
    localparam int ACK_DEPTH = 2;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    tl_c_beat_t c_bits_i = '0;
    logic       c_valid_i = 1'b0;
    logic       c_ready_o;
    tl_c_beat_t oup_bits_o;
    logic       oup_valid_o;
    logic       oup_ready_i = 1'b0;
    tl_d_beat_t d_bits_o;
    logic       d_valid_o;
    logic       d_ready_i = 1'b0;
    logic       busy_o;
    logic       err_o;

    tl_c_sink #(.DEPTH(DEPTH), .ACK_DEPTH(ACK_DEPTH)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .c_bits_i(c_bits_i), .c_valid_i(c_valid_i), .c_ready_o(c_ready_o),
        .oup_bits_o(oup_bits_o), .oup_valid_o(oup_valid_o), .oup_ready_i(oup_ready_i),
        .d_bits_o(d_bits_o), .d_valid_o(d_valid_o), .d_ready_i(d_ready_i),
        .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: every accepted beat in order, tagged with its burst role.
    typedef struct {
        tl_c_beat_t bits;
        bit         last;
        bit         ack;
        bit         ill;
        tl_d_beat_t d;
    } ent_t;

    ent_t       beat_q[$];
    tl_d_beat_t ack_q[$];
    int         in_left = 0;
    bit         in_rel = 1'b0;
    tl_d_beat_t in_hdr = '0;
    bit         out_open = 1'b0;
    bit         err_m = 1'b0;
    bit         exp_ov;
    ent_t       pop_e;

    task automatic model_accept(input tl_c_beat_t b);
        ent_t e;
        e.bits = b; e.last = 1'b1; e.ack = 1'b0; e.ill = 1'b0; e.d = '0;
        if (in_left == 0) begin
            if (b.opcode < 3'd4) begin
                e.ill = 1'b1;
            end else begin
                in_rel        = (b.opcode >= 3'd6);
                in_hdr        = '0;
                in_hdr.opcode = 3'd6;
                in_hdr.size   = b.size;
                in_hdr.source = b.source;
                if (b.size != 10'd0) begin
                    in_left = int'(b.size);
                    e.last  = 1'b0;
                end
            end
        end else begin
            in_left--;
            e.last = (in_left == 0);
        end
        if (e.last && !e.ill && in_rel) begin
            e.ack = 1'b1;
            e.d   = in_hdr;
        end
        beat_q.push_back(e);
    endtask

    always @(negedge clk_i) begin
        if (!rst_i) begin
            chk("rst_oup_valid", 128'(oup_valid_o), 128'(0));
            chk("rst_d_valid", 128'(d_valid_o), 128'(0));
            chk("rst_busy", 128'(busy_o), 128'(0));
            chk("rst_err", 128'(err_o), 128'(0));
            beat_q.delete();
            ack_q.delete();
            in_left  = 0;
            out_open = 1'b0;
            err_m    = 1'b0;
        end else begin
            exp_ov = (beat_q.size() > 0) && !(beat_q[0].ack && ack_q.size() >= ACK_DEPTH);
            chk("c_ready", 128'(c_ready_o), 128'(beat_q.size() < DEPTH));
            chk("oup_valid", 128'(oup_valid_o), 128'(exp_ov));
            if (exp_ov && oup_valid_o) chk("oup_bits", 128'(oup_bits_o), 128'(beat_q[0].bits));
            chk("d_valid", 128'(d_valid_o), 128'(ack_q.size() > 0));
            if (ack_q.size() > 0 && d_valid_o) chk("d_bits", 128'(d_bits_o), 128'(ack_q[0]));
            chk("busy", 128'(busy_o), 128'(beat_q.size() > 0 || out_open || ack_q.size() > 0));
            chk("err", 128'(err_o), 128'(err_m));
            if (d_valid_o && d_ready_i && ack_q.size() > 0) begin
                $display("d ack   op=%0d size=%0d src=%0d", d_bits_o.opcode, d_bits_o.size, d_bits_o.source);
                void'(ack_q.pop_front());
            end
            if (oup_valid_o && oup_ready_i && beat_q.size() > 0) begin
                pop_e = beat_q.pop_front();
                $display("oup beat op=%0d size=%0d src=%0d last=%0b", oup_bits_o.opcode,
                         oup_bits_o.size, oup_bits_o.source, pop_e.last);
                if (pop_e.ack) ack_q.push_back(pop_e.d);
                if (pop_e.ill) err_m = 1'b1;
                out_open = !pop_e.last;
            end
            if (c_valid_i && c_ready_o) model_accept(c_bits_i);
        end
    end

    bit rand_rdy = 1'b0;
    bit oup_rdy_set = 1'b1;
    bit d_rdy_set = 1'b1;
    int rdy_pct = 75;

    always @(posedge clk_i) begin
        #2;
        if (rand_rdy) begin
            oup_ready_i = (int'($urandom_range(0, 99)) < rdy_pct);
            d_ready_i   = (int'($urandom_range(0, 99)) < rdy_pct);
        end else begin
            oup_ready_i = oup_rdy_set;
            d_ready_i   = d_rdy_set;
        end
    end

    function automatic tl_c_beat_t mk(input int op, input int sz, input int src);
        tl_c_beat_t b;
        b.opcode  = 3'(op);
        b.param   = 3'($urandom_range(0, 7));
        b.size    = 10'(sz);
        b.source  = 4'(src);
        b.address = $urandom;
        b.data    = $urandom;
        return b;
    endfunction

    task automatic sync();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_beat(input tl_c_beat_t b);
        int n;
        c_bits_i  = b;
        c_valid_i = 1'b1;
        for (n = 0; n < 2000; n++) begin
            @(negedge clk_i);
            if (c_ready_o) break;
        end
        chk("send_accept_in_time", 128'(n < 2000), 128'(1));
        @(posedge clk_i);
        #1;
        c_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        for (n = 0; n < 2000; n++) begin
            @(negedge clk_i);
            if (!busy_o) break;
        end
        chk("idle_in_time", 128'(n < 2000), 128'(1));
        sync();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        tl_c_beat_t b5;
        int op, sz, src, beats;
        #1 rst_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b1;

        // 1: single Release
        send_beat(mk(6, 0, 3));
        @(negedge clk_i);
        chk("t1_oup_valid", 128'(oup_valid_o), 128'(1));
        chk("t1_d_not_yet", 128'(d_valid_o), 128'(0));
        @(negedge clk_i);
        chk("t1_d_valid", 128'(d_valid_o), 128'(1));
        chk("t1_d_opcode", 128'(d_bits_o.opcode), 128'(6));
        chk("t1_d_size", 128'(d_bits_o.size), 128'(0));
        chk("t1_d_source", 128'(d_bits_o.source), 128'(3));
        sync();

        // 2: ReleaseData, 4 beats
        for (int i = 0; i < 4; i++) send_beat(mk(7, 3, 5));
        @(negedge clk_i);
        chk("t2_no_early_ack", 128'(d_valid_o), 128'(0));
        @(negedge clk_i);
        chk("t2_d_valid", 128'(d_valid_o), 128'(1));
        chk("t2_d_size", 128'(d_bits_o.size), 128'(3));
        chk("t2_d_source", 128'(d_bits_o.source), 128'(5));
        sync();

        // 3: back-pressure fills the FIFO
        oup_rdy_set = 1'b0;
        for (int i = 0; i < DEPTH; i++) send_beat(mk(4, 0, i));
        @(negedge clk_i);
        chk("t3_full_c_ready", 128'(c_ready_o), 128'(0));
        chk("t3_oup_valid", 128'(oup_valid_o), 128'(1));
        sync();
        b5 = mk(4, 0, 12);
        c_bits_i  = b5;
        c_valid_i = 1'b1;
        repeat (3) begin
            @(negedge clk_i);
            chk("t3_fifth_held", 128'(c_ready_o), 128'(0));
        end
        sync();
        oup_rdy_set = 1'b1;
        send_beat(b5);
        wait_idle();

        // 4: ack FIFO full stalls the third Release
        d_rdy_set = 1'b0;
        for (int i = 1; i <= 3; i++) send_beat(mk(6, 0, i));
        @(negedge clk_i);
        @(negedge clk_i);
        chk("t4_stalled", 128'(oup_valid_o), 128'(0));
        chk("t4_d_valid", 128'(d_valid_o), 128'(1));
        chk("t4_d_source", 128'(d_bits_o.source), 128'(1));
        chk("t4_busy", 128'(busy_o), 128'(1));
        sync();
        d_rdy_set = 1'b1;
        @(negedge clk_i);
        chk("t4_still_stalled", 128'(oup_valid_o), 128'(0));
        @(negedge clk_i);
        chk("t4_released", 128'(oup_valid_o), 128'(1));
        wait_idle();

        // 5: ProbeAckData then illegal opcode (sized, but forwarded as one beat)
        send_beat(mk(5, 1, 7));
        send_beat(mk(5, 1, 7));
        send_beat(mk(2, 2, 8));
        wait_idle();
        @(negedge clk_i);
        chk("t5_err", 128'(err_o), 128'(1));
        chk("t5_no_d", 128'(d_valid_o), 128'(0));
        sync();

        // Random traffic with random ready on both outputs
        rand_rdy = 1'b1;
        for (int t = 0; t < 250; t++) begin
            op    = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(4, 7));
            sz    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(4, 9)) : int'($urandom_range(0, 3));
            src   = int'($urandom_range(0, 15));
            beats = (op < 4) ? 1 : sz + 1;
            for (int k = 0; k < beats; k++) begin
                send_beat(mk(op, sz, src));
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) sync();
            end
            if (t == 125) rdy_pct = 30;
        end
        rand_rdy    = 1'b0;
        oup_rdy_set = 1'b1;
        d_rdy_set   = 1'b1;
        wait_idle();
        chk("rand_drained", 128'(beat_q.size() + ack_q.size()), 128'(0));
        @(negedge clk_i);
        chk("t5_err_sticky", 128'(err_o), 128'(1));
        sync();

        // 6: reset in the middle of a burst
        send_beat(mk(7, 3, 10));
        send_beat(mk(7, 3, 10));
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("t6_oup_valid", 128'(oup_valid_o), 128'(0));
        chk("t6_d_valid", 128'(d_valid_o), 128'(0));
        chk("t6_busy", 128'(busy_o), 128'(0));
        sync();
        rst_i = 1'b1;
        send_beat(mk(6, 0, 9));
        @(negedge clk_i);
        chk("t6_oup_valid_after", 128'(oup_valid_o), 128'(1));
        @(negedge clk_i);
        chk("t6_d_valid_after", 128'(d_valid_o), 128'(1));
        chk("t6_d_source", 128'(d_bits_o.source), 128'(9));
        chk("t6_err_cleared", 128'(err_o), 128'(0));
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
